// File: rtl/data_bus_bridge_if.sv
// Load/store bus bundle between the core, the bridge, the data RAM and the GEMM register window.
// The slave modport is the bridge's view; master is the view of everything around it.
interface data_bus_bridge_if #(
  parameter int RAM_AW = 12
);
  logic              cs;
  logic              mem_rd_wr;
  logic [3:0]        mask;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              mem_valid;
  logic              bus_err;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              per_req;
  logic              per_we;
  logic [11:0]       per_addr;
  logic [31:0]       per_wdata;
  logic [31:0]       per_rdata;
  logic              per_ack;

  modport slave (
    input  cs, mem_rd_wr, mask, mem_addr, mem_write_data, ram_rdata, per_rdata, per_ack,
    output mem_read_data, mem_valid, bus_err, ram_en, ram_we, ram_addr, ram_wdata,
           per_req, per_we, per_addr, per_wdata
  );

  modport master (
    output cs, mem_rd_wr, mask, mem_addr, mem_write_data, ram_rdata, per_rdata, per_ack,
    input  mem_read_data, mem_valid, bus_err, ram_en, ram_we, ram_addr, ram_wdata,
           per_req, per_we, per_addr, per_wdata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// Routes single-word core load/stores to data RAM or the GEMM register window, with
// fully registered outputs and error completion for unmapped or timed-out accesses.
module data_bus_bridge #(
  parameter logic [31:0] RAM_BYTES   = 32'h0000_4000,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  parameter logic [31:0] PERIPH_MASK = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT     = 16
) (
  input logic              clk,
  input logic              reset,
  data_bus_bridge_if.slave bus
);

  localparam int AW = $clog2(RAM_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    RAM_WAIT,
    PER_REQ,
    RESP
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        rd_q;
  logic        from_ram_q;
  logic        unmapped_q;
  logic        timeout_q;
  logic [31:0] per_data_q;

  // Single FSM; every bus output is a register so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      rd_q              <= 1'b0;
      from_ram_q        <= 1'b0;
      unmapped_q        <= 1'b0;
      timeout_q         <= 1'b0;
      per_data_q        <= '0;
      bus.mem_read_data <= '0;
      bus.mem_valid     <= 1'b0;
      bus.bus_err       <= 1'b0;
      bus.ram_en        <= 1'b0;
      bus.ram_we        <= '0;
      bus.ram_addr      <= '0;
      bus.ram_wdata     <= '0;
      bus.per_req       <= 1'b0;
      bus.per_we        <= 1'b0;
      bus.per_addr      <= '0;
      bus.per_wdata     <= '0;
    end else begin
      bus.mem_valid <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= '0;

      case (state)
        IDLE: begin
          if (bus.cs) begin
            rd_q       <= bus.mem_rd_wr;
            cnt        <= '0;
            unmapped_q <= 1'b0;
            timeout_q  <= 1'b0;
            from_ram_q <= 1'b0;
            if (bus.mem_addr < RAM_BYTES) begin
              from_ram_q    <= 1'b1;
              bus.ram_en    <= 1'b1;
              bus.ram_we    <= bus.mem_rd_wr ? 4'b0000 : bus.mask;
              bus.ram_addr  <= bus.mem_addr[AW-1:2];
              bus.ram_wdata <= bus.mem_write_data;
              state         <= RAM_ACC;
            end else if ((bus.mem_addr & PERIPH_MASK) == PERIPH_BASE) begin
              bus.per_req   <= 1'b1;
              bus.per_we    <= ~bus.mem_rd_wr;
              bus.per_addr  <= bus.mem_addr[11:0];
              bus.per_wdata <= bus.mem_write_data;
              state         <= PER_REQ;
            end else begin
              // Unmapped requests idle one cycle in RAM_WAIT so they complete at n+2 like RAM hits.
              unmapped_q <= 1'b1;
              state      <= RAM_WAIT;
            end
          end
        end

        RAM_ACC: begin
          if (RAM_LATENCY == 1) begin
            state <= RESP;
          end else begin
            cnt   <= 16'(RAM_LATENCY - 2);
            state <= RAM_WAIT;
          end
        end

        RAM_WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 16'd1;
        end

        PER_REQ: begin
          if (bus.per_ack) begin
            per_data_q  <= bus.per_rdata;
            bus.per_req <= 1'b0;
            state       <= RESP;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            timeout_q   <= 1'b1;
            bus.per_req <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RESP: begin
          // RAM data is sampled here, RAM_LATENCY edges after the ram_en cycle.
          bus.mem_valid <= 1'b1;
          bus.bus_err   <= unmapped_q | timeout_q;
          if (unmapped_q)      bus.mem_read_data <= '0;
          else if (timeout_q)  bus.mem_read_data <= 32'hDEAD_BEEF;
          else if (!rd_q)      bus.mem_read_data <= '0;
          else if (from_ram_q) bus.mem_read_data <= bus.ram_rdata;
          else                 bus.mem_read_data <= per_data_q;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench for data_bus_bridge: behavioural RAM with one-cycle latency plus a
// scripted peripheral that acks after a chosen number of per_req cycles (or never).
module tb_data_bus_bridge;

  logic clk;
  logic reset;

  data_bus_bridge_if #(.RAM_AW(12)) bus ();

  data_bus_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural data RAM, one cycle read latency, byte-lane writes.
  logic [31:0] ram_mem [0:4095];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  logic        obs_done;
  logic [31:0] obs_data;
  logic        obs_err;
  int          obs_lat;
  int          obs_req;
  int          obs_ram;
  logic [3:0]  obs_we;
  logic [11:0] obs_raddr;
  logic [31:0] obs_rwdata;
  logic [11:0] obs_paddr;
  logic        obs_pwe;
  logic [31:0] obs_pwdata;
  logic        obs_after;
  logic [31:0] obs_hold;

  // Drives one request from a negedge, holds cs until mem_valid, records what the DUT did.
  task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] msk, input int ack_delay, input logic [31:0] prdata);
    bus.cs = 1'b1; bus.mem_rd_wr = rd; bus.mask = msk;
    bus.mem_addr = addr; bus.mem_write_data = wdata; bus.per_rdata = prdata;
    obs_done = 1'b0; obs_lat = 0; obs_req = 0; obs_ram = 0;
    obs_data = '0; obs_err = 1'b0; obs_we = '0; obs_raddr = '0; obs_rwdata = '0;
    obs_paddr = '0; obs_pwe = 1'b0; obs_pwdata = '0;
    for (int i = 1; i <= 200 && !obs_done; i++) begin
      @(negedge clk);
      if (bus.per_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_paddr = bus.per_addr; obs_pwe = bus.per_we; obs_pwdata = bus.per_wdata;
        end
      end
      if (bus.ram_en) begin
        obs_ram++; obs_we = bus.ram_we; obs_raddr = bus.ram_addr; obs_rwdata = bus.ram_wdata;
      end
      bus.per_ack = bus.per_req && (obs_req == ack_delay);
      if (bus.mem_valid) begin
        obs_done = 1'b1; obs_lat = i; obs_data = bus.mem_read_data; obs_err = bus.bus_err;
      end
    end
    bus.cs = 1'b0; bus.per_ack = 1'b0;
    @(negedge clk);
    obs_after = bus.mem_valid | bus.bus_err;
    obs_hold  = bus.mem_read_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cs = 1'b0; bus.mem_rd_wr = 1'b0; bus.mask = '0; bus.mem_addr = '0;
    bus.mem_write_data = '0; bus.per_rdata = '0; bus.per_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, bus.bus_err, bus.ram_en, bus.per_req, bus.per_we} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000",
               {bus.mem_valid, bus.bus_err, bus.ram_en, bus.per_req, bus.per_we});
    end
    checks++;
    if ({bus.mem_read_data, bus.ram_we, bus.ram_addr, bus.per_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: rdata %h we %h raddr %h paddr %h expected all 0",
               bus.mem_read_data, bus.ram_we, bus.ram_addr, bus.per_addr);
    end
  endtask

  task automatic test_ram_word();
    exp_t e;
    sb.push_back('{data: 32'h0, err: 1'b0, lat: 3});
    issue(1'b0, 32'h10, 32'hCAFE_BABE, 4'hF, 0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_lat !== e.lat) begin
      errors++; $display("[TB] FAIL ram_wr_latency: got %0d (done %b) expected %0d", obs_lat, obs_done, e.lat);
    end
    checks++;
    if (obs_ram !== 1 || obs_we !== 4'hF || obs_raddr !== 12'd4 || obs_rwdata !== 32'hCAFE_BABE) begin
      errors++;
      $display("[TB] FAIL ram_wr_strobe: en %0d we %h addr %h wdata %h expected 1 f 004 cafebabe",
               obs_ram, obs_we, obs_raddr, obs_rwdata);
    end
    checks++;
    if (obs_data !== e.data || obs_err !== e.err) begin
      errors++; $display("[TB] FAIL ram_wr_resp: data %h err %b expected %h %b", obs_data, obs_err, e.data, e.err);
    end

    sb.push_back('{data: 32'hCAFE_BABE, err: 1'b0, lat: 3});
    issue(1'b1, 32'h10, 32'h0, 4'hF, 0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL ram_rd: lat %0d data %h err %b expected %0d %h %b",
               obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
    checks++;
    if (obs_we !== 4'h0 || obs_ram !== 1) begin
      errors++; $display("[TB] FAIL ram_rd_we: we %h en %0d expected 0 1", obs_we, obs_ram);
    end
    checks++;
    if (obs_after !== 1'b0 || obs_hold !== 32'hCAFE_BABE) begin
      errors++; $display("[TB] FAIL ram_rd_hold: pulse %b hold %h expected 0 cafebabe", obs_after, obs_hold);
    end
  endtask

  task automatic test_byte_write();
    exp_t e;
    sb.push_back('{data: 32'h0, err: 1'b0, lat: 3});
    issue(1'b0, 32'h12, 32'h00AB_0000, 4'b0100, 0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_we !== 4'b0100 || obs_raddr !== 12'd4 || obs_data !== e.data) begin
      errors++;
      $display("[TB] FAIL byte_wr: done %b we %b addr %h data %h expected 1 0100 004 %h",
               obs_done, obs_we, obs_raddr, obs_data, e.data);
    end
    sb.push_back('{data: 32'hCAAB_BABE, err: 1'b0, lat: 3});
    issue(1'b1, 32'h12, 32'h0, 4'b0001, 0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_data !== e.data || obs_lat !== e.lat) begin
      errors++; $display("[TB] FAIL byte_rd: data %h lat %0d expected %h %0d", obs_data, obs_lat, e.data, e.lat);
    end
  endtask

  task automatic test_periph_read();
    exp_t e;
    sb.push_back('{data: 32'h1234_5678, err: 1'b0, lat: 5});
    issue(1'b1, 32'h8000_0024, 32'h0, 4'hF, 3, 32'h1234_5678);
    e = sb.pop_front();
    checks++;
    if (obs_paddr !== 12'h024 || obs_pwe !== 1'b0 || obs_req !== 3 || obs_ram !== 0) begin
      errors++;
      $display("[TB] FAIL per_rd_req: addr %h we %b req_cycles %0d ram_en %0d expected 024 0 3 0",
               obs_paddr, obs_pwe, obs_req, obs_ram);
    end
    checks++;
    if (!obs_done || obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL per_rd_resp: lat %0d data %h err %b expected %0d %h %b",
               obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_periph_ack_first();
    exp_t e;
    sb.push_back('{data: 32'hA5A5_0F0F, err: 1'b0, lat: 3});
    issue(1'b1, 32'h8000_0FFC, 32'h0, 4'hF, 1, 32'hA5A5_0F0F);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_lat !== e.lat || obs_data !== e.data || obs_req !== 1 || obs_paddr !== 12'hFFC) begin
      errors++;
      $display("[TB] FAIL per_ack_first: lat %0d data %h req %0d addr %h expected %0d %h 1 ffc",
               obs_lat, obs_data, obs_req, obs_paddr, e.lat, e.data);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{data: 32'hDEAD_BEEF, err: 1'b1, lat: 18});
    issue(1'b0, 32'h8000_0200, 32'h55AA_55AA, 4'hF, -1, 32'h0);
    e = sb.pop_front();
    checks++;
    if (obs_req !== 16 || obs_pwe !== 1'b1 || obs_pwdata !== 32'h55AA_55AA) begin
      errors++;
      $display("[TB] FAIL timeout_req: req_cycles %0d we %b wdata %h expected 16 1 55aa55aa",
               obs_req, obs_pwe, obs_pwdata);
    end
    checks++;
    if (!obs_done || obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err || obs_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_resp: lat %0d data %h err %b after %b expected %0d %h %b 0",
               obs_lat, obs_data, obs_err, obs_after, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_unmapped();
    exp_t e;
    sb.push_back('{data: 32'h0, err: 1'b1, lat: 3});
    issue(1'b1, 32'h0001_0000, 32'h0, 4'hF, 1, 32'hFFFF_FFFF);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL unmapped_resp: lat %0d data %h err %b expected %0d %h %b",
               obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
    checks++;
    if (obs_ram !== 0 || obs_req !== 0) begin
      errors++; $display("[TB] FAIL unmapped_strobe: ram_en %0d per_req %0d expected 0 0", obs_ram, obs_req);
    end
  endtask

  task automatic test_reset_mid_periph();
    exp_t e;
    int   stray;
    bus.cs = 1'b1; bus.mem_rd_wr = 1'b1; bus.mem_addr = 32'h8000_0100; bus.per_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.per_req !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_pre: per_req %b expected 1", bus.per_req);
    end
    reset = 1'b1; bus.cs = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.per_req !== 1'b0 || bus.mem_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_drop: per_req %b mem_valid %b expected 0 0", bus.per_req, bus.mem_valid);
    end
    reset = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_valid || bus.per_req) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("[TB] FAIL rst_mid_stray: %0d cycles of activity expected 0", stray);
    end
    sb.push_back('{data: 32'hCAAB_BABE, err: 1'b0, lat: 3});
    issue(1'b1, 32'h10, 32'h0, 4'hF, 0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (!obs_done || obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL rst_mid_after: lat %0d data %h err %b expected %0d %h %b",
               obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [6];
    logic [31:0] datas [6];
    logic        rds   [6];
    exp_t        e;
    int          idx, last, ram_cnt, pulses;
    for (int k = 0; k < 3; k++) begin
      addrs[k] = 32'h40 + 32'(4 * k); datas[k] = $urandom; rds[k] = 1'b0;
      addrs[k+3] = addrs[k]; datas[k+3] = 32'h0; rds[k+3] = 1'b1;
    end
    for (int k = 0; k < 3; k++) sb.push_back('{data: 32'h0, err: 1'b0, lat: 3});
    for (int k = 0; k < 3; k++) sb.push_back('{data: datas[k], err: 1'b0, lat: 3});
    idx = 0; last = 0; ram_cnt = 0; pulses = 0;
    bus.cs = 1'b1; bus.mask = 4'hF; bus.mem_rd_wr = rds[0];
    bus.mem_addr = addrs[0]; bus.mem_write_data = datas[0];
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.ram_en) ram_cnt++;
      if (bus.mem_valid) begin
        pulses++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if (bus.mem_read_data !== e.data || bus.bus_err !== e.err || (i - last) !== e.lat) begin
            errors++;
            $display("[TB] FAIL b2b_%0d: data %h err %b spacing %0d expected %h %b %0d",
                     idx, bus.mem_read_data, bus.bus_err, i - last, e.data, e.err, e.lat);
          end
        end
        last = i;
        idx++;
        if (idx < 6) begin
          bus.mem_rd_wr = rds[idx]; bus.mem_addr = addrs[idx]; bus.mem_write_data = datas[idx];
        end else begin
          bus.cs = 1'b0;
        end
      end
    end
    bus.cs = 1'b0;
    checks++;
    if (pulses !== 6 || ram_cnt !== 6 || sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: pulses %0d ram_en %0d left %0d expected 6 6 0",
               pulses, ram_cnt, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_ram_word();
    test_byte_write();
    test_periph_read();
    test_periph_ack_first();
    test_timeout();
    test_unmapped();
    test_reset_mid_periph();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
